// File: rtl/load_ctrl.sv
// Load unit controller: accepts one load at a time, reads the containing memory word,
// then returns the aligned, sign- or zero-extended result with a one-cycle done/err pulse.
module load_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [2:0]  op,
    output logic        busy,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StResp
    } state_e;

    localparam logic [2:0] OpLw  = 3'b000;
    localparam logic [2:0] OpLh  = 3'b001;
    localparam logic [2:0] OpLhu = 3'b010;
    localparam logic [2:0] OpLb  = 3'b011;
    localparam logic [2:0] OpLbu = 3'b100;

    // Last wait-count value before the read is abandoned.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_ok;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] load_data;

    // A request is accepted only for a legal op at a naturally aligned address.
    always_comb begin
        req_ok = 1'b0;
        case (op)
            OpLw:         req_ok = (addr[1:0] == 2'b00);
            OpLh, OpLhu:  req_ok = ~addr[0];
            OpLb, OpLbu:  req_ok = 1'b1;
            default:      req_ok = 1'b0;
        endcase
    end

    always_comb begin
        half     = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_sel = 8'h00;
        unique case (off_q)
            2'b00: byte_sel = mem_rdata[7:0];
            2'b01: byte_sel = mem_rdata[15:8];
            2'b10: byte_sel = mem_rdata[23:16];
            2'b11: byte_sel = mem_rdata[31:24];
        endcase

        load_data = 32'h0;
        case (op_q)
            OpLw:    load_data = mem_rdata;
            OpLh:    load_data = {{16{half[15]}}, half};
            OpLhu:   load_data = {16'h0, half};
            OpLb:    load_data = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   load_data = {24'h0, byte_sel};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        off_d      = off_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;

        case (state_q)
            StIdle: begin
                if (req) begin
                    if (req_ok) begin
                        state_d    = StRead;
                        op_d       = op;
                        off_d      = addr[1:0];
                        mem_addr_d = {addr[31:2], 2'b00};
                        cnt_d      = 8'h00;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
                end
            end
            StRead: begin
                // An ack in the timeout cycle still completes the load cleanly.
                if (mem_ack) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = load_data;
                end else if (cnt_q == CntLast) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= 3'b000;
            off_q      <= 2'b00;
            mem_addr_q <= 32'h0;
            cnt_q      <= 8'h00;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign mem_rd   = (state_q == StRead);
    assign mem_addr = mem_addr_q;
    assign done     = (state_q == StResp);
    assign err      = (state_q == StResp) & err_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_load_ctrl.sv
// Directed bench for load_ctrl: hand-computed loads, errors, timeout, reset abort and
// request/ack filtering, all checked cycle by cycle just after each rising edge.
module tb_load_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  op;
    logic        busy;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;

    int vectors;
    int miscompares;

    load_ctrl #(
        .TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .op        (op),
        .busy      (busy),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; for a legal one, ack after wait_cycles idle READ cycles.
    task automatic load(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d, input int wait_cycles, input logic legal,
                        input logic [31:0] exp_d);
        req  = 1'b1;
        op   = o;
        addr = a;
        tick();
        req  = 1'b0;
        if (legal) begin
            check({tag, " mem_rd"}, 32'(mem_rd), 32'd1);
            check({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
            for (int i = 0; i < wait_cycles; i++) begin
                tick();
                check({tag, " mem_rd wait"}, 32'(mem_rd), 32'd1);
            end
            mem_ack   = 1'b1;
            mem_rdata = d;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end else begin
            check({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " err"}, 32'(err), legal ? 32'd0 : 32'd1);
        check({tag, " rdata"}, rdata, exp_d);
        tick();
        check({tag, " done drop"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " rdata hold"}, rdata, exp_d);
    endtask

    logic [5:0] exp_rd_pat;
    logic [5:0] exp_done_pat;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = 1'b0;
        addr        = 32'h0;
        op          = 3'b000;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst rdata", rdata, 32'h0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);

        // Byte and halfword extraction
        load("lb 1003", 3'b011, 32'h0000_1003, 32'h80FF_1234, 1, 1'b1, 32'hFFFF_FF80);
        load("lhu 2002", 3'b010, 32'h0000_2002, 32'h9ABC_5678, 0, 1'b1, 32'h0000_9ABC);
        load("lh 2002", 3'b001, 32'h0000_2002, 32'h9ABC_5678, 2, 1'b1, 32'hFFFF_9ABC);
        load("lh 0", 3'b001, 32'h0000_0000, 32'h1234_8001, 0, 1'b1, 32'hFFFF_8001);
        load("lb 1001", 3'b011, 32'h0000_1001, 32'h80FF_1234, 0, 1'b1, 32'h0000_0012);
        load("lbu 2", 3'b100, 32'h0000_0002, 32'h0081_0000, 0, 1'b1, 32'h0000_0081);
        load("lw 40", 3'b000, 32'hCAFE_0040, 32'hA5A5_0F0F, 3, 1'b1, 32'hA5A5_0F0F);

        // Error completions: misaligned and illegal
        load("lw 6", 3'b000, 32'h0000_0006, 32'h0, 0, 1'b0, 32'h0);
        load("op7", 3'b111, 32'h0000_0000, 32'h0, 0, 1'b0, 32'h0);
        load("lh 3", 3'b001, 32'h0000_0003, 32'h0, 0, 1'b0, 32'h0);

        // Timeout: 15 READ cycles without ack
        req  = 1'b1;
        op   = 3'b000;
        addr = 32'h0000_0010;
        tick();
        req  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("tmo mem_rd", 32'(mem_rd), 32'd1);
            check("tmo no done", 32'(done), 32'd0);
            tick();
        end
        check("tmo done", 32'(done), 32'd1);
        check("tmo err", 32'(err), 32'd1);
        check("tmo rdata", rdata, 32'h0);
        tick();

        // Ack in the 15th READ cycle beats the timeout
        req  = 1'b1;
        addr = 32'h0000_0010;
        tick();
        req  = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("ack15 mem_rd", 32'(mem_rd), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        tick();
        mem_ack   = 1'b0;
        check("ack15 done", 32'(done), 32'd1);
        check("ack15 err", 32'(err), 32'd0);
        check("ack15 rdata", rdata, 32'h1122_3344);
        tick();

        // Reset in the second READ cycle aborts with no done pulse
        req  = 1'b1;
        op   = 3'b000;
        addr = 32'h0000_0020;
        tick();
        req  = 1'b0;
        tick();
        rst     = 1'b1;
        mem_ack = 1'b1;
        tick();
        rst     = 1'b0;
        mem_ack = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort mem_rd", 32'(mem_rd), 32'd0);
        check("abort rdata", rdata, 32'h0);
        check("abort done", 32'(done), 32'd0);
        check("abort mem_addr", mem_addr, 32'h0);
        tick();
        check("abort no late done", 32'(done), 32'd0);
        load("lbu 1", 3'b100, 32'h0000_0001, 32'h0000_AB00, 0, 1'b1, 32'h0000_00AB);

        // req and mem_ack both held high: READ, RESP, IDLE repeating
        exp_rd_pat   = 6'b001001;
        exp_done_pat = 6'b010010;
        req       = 1'b1;
        op        = 3'b000;
        addr      = 32'h0000_0080;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("hold mem_rd", 32'(mem_rd), 32'(exp_rd_pat[i]));
            check("hold done", 32'(done), 32'(exp_done_pat[i]));
            tick();
        end
        req = 1'b0;
        // Pattern ends having just accepted a request; finish it out.
        check("hold re-read", 32'(mem_rd), 32'd1);
        tick();
        tick();

        // Stray ack in IDLE does nothing
        mem_rdata = 32'h7777_7777;
        tick();
        tick();
        check("stray busy", 32'(busy), 32'd0);
        check("stray done", 32'(done), 32'd0);
        check("stray rdata", rdata, 32'h0BAD_F00D);
        mem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
